// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response front end that sequences one ALU operation at a time
module alu_op_sequencer #(
    parameter int unsigned DIV_CYCLES = 34
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [15:0] alu_opp,
    input  logic [63:0] alu_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_z,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] OP_DIV      = 4'd4;
    localparam logic [3:0] OP_FIRST_BAD = 4'd14;
    localparam logic [7:0] DIV_LOAD    = 8'(DIV_CYCLES - 1);

    state_t     state;
    logic [3:0] op;
    logic [7:0] div_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            op      <= 4'd0;
            alu_x   <= 32'd0;
            alu_y   <= 32'd0;
            rsp_z   <= 64'd0;
            rsp_err <= 1'b0;
            div_cnt <= 8'd0;
        end else if (flush) begin
            // Abort keeps the last response and operands; only the sequence is dropped.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op    <= req_op;
                        alu_x <= req_x;
                        alu_y <= req_y;
                        if (req_op >= OP_FIRST_BAD) begin
                            rsp_z   <= 64'd0;
                            rsp_err <= 1'b1;
                            state   <= DONE;
                        end else if (req_op == OP_DIV) begin
                            div_cnt <= DIV_LOAD;
                            state   <= DIV_WAIT;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    rsp_z   <= alu_z;
                    rsp_err <= 1'b0;
                    state   <= DONE;
                end
                DIV_WAIT: begin
                    if (div_cnt == 8'd0) begin
                        rsp_z   <= alu_z;
                        rsp_err <= 1'b0;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from registered state only, so the select cannot glitch between edges
    // and falls to zero immediately when the async reset clears the state.
    always_comb begin
        alu_opp = 16'h0000;
        case (state)
            ISSUE:    alu_opp = 16'h0001 << op;
            DIV_WAIT: alu_opp = 16'h0010;
            default:  alu_opp = 16'h0000;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
